// File: rtl/hbm_sched_pkg.sv
// Shared types and limits for the HBM read scheduler.
// Holds the FSM state encoding and the round-robin pointer wrap helper.
package hbm_sched_pkg;

   localparam int C_MIN_REQ = 2;
   localparam int C_MAX_REQ = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_CMPL  = 3'd4
   } sched_state_e;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);

   localparam int IDW1 = IDW + 1;

   logic            found;
   logic [IDW1-1:0] cand;

   // One spare bit keeps ptr + offset from overflowing before the wrap.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + IDW1'(i);
         if (cand >= IDW1'(N)) begin
            cand = cand - IDW1'(N);
         end
         if (!found && req[cand[IDW-1:0]]) begin
            found                = 1'b1;
            gnt[cand[IDW-1:0]]   = 1'b1;
            idx                  = cand[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/hbm_read_scheduler.sv
// Round-robin sharing of one HBM read master between several requesters.
// One descriptor is in flight at a time; completion is returned as a one-hot pulse.
//
// state | meaning
// IDLE  | waiting for any req_valid; ready goes to the arbitration winner
// GRANT | descriptor latched; zero-size requests skip the master
// START | one-cycle rd_start to the read master
// WAIT  | waiting for rd_done
// CMPL  | one-cycle req_done to the granted requester
module hbm_read_scheduler
   import hbm_sched_pkg::*;
#(
   parameter int  C_NUM_REQ          = 4,
   parameter int  C_M_AXI_ADDR_WIDTH = 64,
   localparam int C_ID_WIDTH         = $clog2(C_NUM_REQ)
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [C_NUM_REQ-1:0]                    req_valid,
   output logic [C_NUM_REQ-1:0]                    req_ready,
   input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_size,
   output logic [C_NUM_REQ-1:0]                    req_done,
   output logic                                    rd_start,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]           rd_addr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]           rd_size,
   input  logic                                    rd_done,
   output logic [C_ID_WIDTH-1:0]                   grant_id,
   output logic                                    busy
);

   localparam int W = C_M_AXI_ADDR_WIDTH;

   if (C_NUM_REQ < C_MIN_REQ || C_NUM_REQ > C_MAX_REQ) begin : g_bad_num_req
      $error("C_NUM_REQ out of range");
   end

   sched_state_e          state_q, state_d;
   logic [C_ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [C_ID_WIDTH-1:0] gid_q, gid_d;
   logic [W-1:0]          addr_q, addr_d;
   logic [W-1:0]          size_q, size_d;
   logic [C_NUM_REQ-1:0]  arb_gnt;
   logic [C_ID_WIDTH-1:0] arb_idx;

   rr_arbiter #(
      .N   (C_NUM_REQ),
      .IDW (C_ID_WIDTH)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      addr_d    = addr_q;
      size_d    = size_q;
      req_ready = '0;
      req_done  = '0;
      rd_start  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = arb_gnt;
            if (|req_valid) begin
               addr_d  = req_addr[int'(arb_idx)*W +: W];
               size_d  = req_size[int'(arb_idx)*W +: W];
               gid_d   = arb_idx;
               ptr_d   = C_ID_WIDTH'(wrap_inc(int'(arb_idx), C_NUM_REQ));
               state_d = S_GRANT;
            end
         end
         // The read master underflows its length on zero, so never start it.
         S_GRANT: state_d = (size_q == '0) ? S_CMPL : S_START;
         S_START: begin
            rd_start = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (rd_done) begin
               state_d = S_CMPL;
            end
         end
         S_CMPL: begin
            req_done[gid_q] = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_addr  = addr_q;
   assign rd_size  = size_q;
   assign grant_id = gid_q;
   assign busy     = (state_q != S_IDLE);

   a_rd_done_only_in_wait: assert property (
      @(posedge aclk) disable iff (areset) rd_done |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_hbm_read_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of round-robin service and per-request timing.
module tb_hbm_read_scheduler;

   localparam int N = 4;
   localparam int W = 64;

   logic             aclk = 1'b0;
   logic             areset;
   logic [N-1:0]     req_valid, req_ready, req_done;
   logic [N*W-1:0]   req_addr, req_size;
   logic             rd_start, rd_done, busy;
   logic [W-1:0]     rd_addr, rd_size;
   logic [1:0]       grant_id;

   int               n_chk = 0;
   int               n_err = 0;

   logic [N-1:0]     m_valid;
   logic [63:0]      m_addr[N];
   logic [63:0]      m_size[N];
   int               m_ptr;

   hbm_read_scheduler #(
      .C_NUM_REQ          (N),
      .C_M_AXI_ADDR_WIDTH (W)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_done  (req_done),
      .rd_start  (rd_start),
      .rd_addr   (rd_addr),
      .rd_size   (rd_size),
      .rd_done   (rd_done),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] onehot(input int g);
      return 64'(1) << g;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         if (v[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = m_valid[i];
         req_addr[i*W +: W]    = m_addr[i];
         req_size[i*W +: W]    = m_size[i];
      end
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] s);
      m_valid[i] = 1'b1;
      m_addr[i]  = a;
      m_size[i]  = s;
   endtask

   function automatic logic [63:0] rand_size();
      if ($urandom_range(0, 3) == 0) return 64'd0;
      return 64'($urandom_range(1, 1 << 20));
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ready"},  64'(req_ready), 64'd0);
      check_eq({tag, "_done"},   64'(req_done),  64'd0);
      check_eq({tag, "_start"},  64'(rd_start),  64'd0);
      check_eq({tag, "_addr"},   rd_addr,        64'd0);
      check_eq({tag, "_size"},   rd_size,        64'd0);
      check_eq({tag, "_gid"},    64'(grant_id),  64'd0);
      check_eq({tag, "_busy"},   64'(busy),      64'd0);
   endtask

   task automatic do_reset();
      m_valid = '0;
      drive();
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      m_ptr  = 0;
   endtask

   // Entered at a negedge with inputs driven and the DUT idle; returns at the
   // negedge where the DUT is idle again (accept may happen right there).
   task automatic serve_one(input int lat, input bit reraise, input bit add_rand);
      int          g;
      logic [63:0] a, s;
      logic [N-1:0] nb;
      g = rr_pick(m_valid, m_ptr);
      a = m_addr[g];
      s = m_size[g];
      #1;
      check_eq("accept_ready", 64'(req_ready), onehot(g));
      check_eq("accept_busy",  64'(busy),      64'd0);
      @(posedge aclk);
      m_ptr = (g + 1) % N;
      @(negedge aclk);
      m_valid[g] = 1'b0;
      if (add_rand) begin
         nb = N'($urandom) & ~m_valid;
         for (int i = 0; i < N; i++) begin
            if (nb[i]) set_req(i, {$urandom, $urandom}, rand_size());
         end
      end
      drive();
      #1;
      check_eq("grant_busy",  64'(busy),      64'd1);
      check_eq("grant_ready", 64'(req_ready), 64'd0);
      check_eq("grant_start", 64'(rd_start),  64'd0);
      check_eq("grant_addr",  rd_addr,        a);
      check_eq("grant_size",  rd_size,        s);
      check_eq("grant_id",    64'(grant_id),  64'(g));
      @(negedge aclk);
      if (s != 0) begin
         check_eq("start_pulse", 64'(rd_start), 64'd1);
         check_eq("start_addr",  rd_addr,       a);
         check_eq("start_size",  rd_size,       s);
         repeat (lat) begin
            @(negedge aclk);
            check_eq("wait_start", 64'(rd_start),  64'd0);
            check_eq("wait_done",  64'(req_done),  64'd0);
            check_eq("wait_ready", 64'(req_ready), 64'd0);
         end
         @(negedge aclk);
         check_eq("wait_start_d", 64'(rd_start), 64'd0);
         rd_done = 1'b1;
         @(negedge aclk);
         rd_done = 1'b0;
      end
      check_eq("cmpl_done",  64'(req_done), onehot(g));
      check_eq("cmpl_start", 64'(rd_start), 64'd0);
      check_eq("cmpl_addr",  rd_addr,       a);
      check_eq("cmpl_busy",  64'(busy),     64'd1);
      if (reraise) begin
         set_req(g, {$urandom, $urandom}, 64'($urandom_range(1, 4096)));
         drive();
         #1;
         check_eq("cmpl_ready", 64'(req_ready), 64'd0);
      end
      @(negedge aclk);
      check_eq("idle_done", 64'(req_done), 64'd0);
      check_eq("idle_busy", 64'(busy),     64'd0);
   endtask

   initial begin
      areset  = 1'b1;
      rd_done = 1'b0;
      m_valid = '0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0;
         m_size[i] = '0;
      end
      drive();
      repeat (2) @(negedge aclk);
      check_idle_outputs("reset");
      areset = 1'b0;
      @(negedge aclk);

      // Single request with the reference descriptor.
      set_req(0, 64'h1000, 64'h2000);
      drive();
      serve_one(3, 1'b0, 1'b0);

      // All four from reset, twice.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) set_req(i, 64'h10000 * (i + 1), 64'h100 * (i + 1));
         drive();
         for (int k = 0; k < N; k++) begin
            check_eq("order_all", 64'(rr_pick(m_valid, m_ptr)), 64'(k));
            serve_one(k, 1'b0, 1'b0);
         end
      end

      // Serve req1 alone to move the pointer to 2, then req1 and req3 together.
      set_req(1, 64'hA000, 64'h40);
      drive();
      serve_one(0, 1'b0, 1'b0);
      set_req(1, 64'hB000, 64'h80);
      set_req(3, 64'hC000, 64'h80);
      drive();
      serve_one(1, 1'b0, 1'b0);
      serve_one(1, 1'b0, 1'b0);

      // Zero-size descriptor never starts the master.
      set_req(2, 64'hD000, 64'h0);
      drive();
      serve_one(0, 1'b0, 1'b0);

      // Back-to-back re-assertion in the completion cycle.
      set_req(0, 64'hE000, 64'h200);
      drive();
      serve_one(2, 1'b1, 1'b0);
      serve_one(0, 1'b0, 1'b0);

      // Reset while waiting for rd_done.
      set_req(2, 64'hF000, 64'h300);
      drive();
      @(posedge aclk);
      @(negedge aclk);
      m_valid = '0;
      drive();
      repeat (2) @(negedge aclk);
      #2;
      areset = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      @(negedge aclk);
      areset = 1'b0;
      m_ptr  = 0;
      repeat (3) begin
         @(negedge aclk);
         check_eq("post_rst_done", 64'(req_done), 64'd0);
         check_eq("post_rst_busy", 64'(busy),     64'd0);
      end
      set_req(1, 64'h1_2000, 64'h400);
      set_req(3, 64'h1_3000, 64'h400);
      drive();
      serve_one(2, 1'b0, 1'b0);
      serve_one(0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         if (m_valid == '0) begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 1) == 1) set_req(i, {$urandom, $urandom}, rand_size());
            end
            if (m_valid == '0) set_req($urandom_range(0, N - 1), {$urandom, $urandom}, rand_size());
            drive();
         end
         serve_one($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
